band_scale_seq: RTL
===================

# band_scale_seq

Time-multiplexed band scaler/summer for the equalizer output stage. Accepts one sample per band (LP, B1, B2, B3, HP) plus one gain per band. Runs all five bands through one shared signed multiplier over five cycles, accumulating with per-term and final saturation. Presents the 16-bit mixed sample on a valid/ready output and replaces the parallel five-multiplier scale-and-sum path.

## Interface
- DATA_W, 16, sample width (signed, two's complement)
- GAIN_W, 12, gain width (unsigned Q1.(GAIN_W-1); 0x800 = 1.0 at default)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_vld  in  1  input sample set valid
- in_rdy  out  1  block can accept a sample set
- lp, b1, b2, b3, hp  in  DATA_W each  signed band samples
- g_lp, g_b1, g_b2, g_b3, g_hp  in  GAIN_W each  unsigned band gains
- out_vld  out  1  mixed sample valid
- out_rdy  in  1  downstream accepts the mixed sample
- out  out  DATA_W  signed saturated mixed sample
- sat_flag  out  1  clipping occurred (only with SAT_FLAG_EN)

## Operation
- States: IDLE, MAC, OUT.
- IDLE
  - in_rdy=1.
  - On in_vld&&in_rdy: capture all samples and gains, clear accumulator, idx=0, go to MAC.
- MAC
  - One band per cycle, order LP, B1, B2, B3, HP (idx 0..4).
  - term = (band × {0,gain}) >>> (GAIN_W-1). The shift is arithmetic, so it floors toward −∞.
  - Saturate term to DATA_W: >0x7FFF → 0x7FFF, <−0x8000 → 0x8000.
  - Add term to a 19-bit signed accumulator; cannot overflow with 5 terms.
  - On idx=4, register out = sat16(acc + term4), go to OUT.
- OUT
  - out_vld=1; out held stable.
  - On out_rdy go to IDLE.
  - in_rdy=0 here; in_vld is ignored outside IDLE.
- Final saturation: acc>32767 → 0x7FFF; acc<−32768 → 0x8000; otherwise acc[15:0].
- Input ports may change freely after acceptance; only captured values are used.
- Reset (any time, including mid-MAC or OUT):
  - State=IDLE, idx=0, accumulator=0, out=0, out_vld=0, sat_flag=0, in_rdy=1 after release.
  - An in-flight transaction is discarded and never emitted.

## Timing
- Accept at edge k. MAC cycles run on edges k+1..k+5; out_vld rises after edge k+5 (latency 5 cycles).
- The output handshake at edge m returns to IDLE; the next accept is no earlier than edge m+1.
- Minimum issue interval is 7 cycles: 5 MAC cycles + 1 OUT cycle with out_rdy high + 1 IDLE cycle.
- out_rdy may be high before out_vld; it has no effect until OUT.
- Backpressure is unbounded: out, out_vld and sat_flag stay constant while out_rdy=0.
- All outputs are registered except in_rdy, which is decoded from state.

## Configuration
- SAT_FLAG_EN defined:
  - sat_flag port exists.
  - Set if any per-term or the final saturation clipped during the transaction.
  - Cleared on accept; valid while out_vld=1.
- SAT_FLAG_EN undefined: the port and its tracking logic are absent. out is bit-identical in both builds.

## Structure
- Shared package eq_pkg holds:
  - state enum (IDLE/MAC/OUT)
  - NUM_BANDS=5
  - ACC_W=19
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000
  - sat16 function (ACC_W → DATA_W clip).
- One sub-module, band_scale_mac: combinational multiply, arithmetic shift and term saturation. It outputs the saturated term and a clip bit. The top level holds the FSM, capture registers, band mux and accumulator.

## Test plan
- Accept, no backpressure: all bands 0x1000, all gains 0x800, out_rdy=1 → out=0x5000, out_vld exactly 5 cycles after accept, sat_flag=0.
- Positive final saturation: all bands 0x7FFF, gains 0x800 → acc=163835, out=0x7FFF, sat_flag=1.
- Term saturation, negative: lp=0x8000, g_lp=0xFFF, other bands 0 → term clipped from −65520, out=0x8000, sat_flag=1.
- Floor rounding: lp=0xFFFF, g_lp=0x400, rest 0 → out=0xFFFF. lp=0x0001, g_lp=0x400 → out=0x0000.
- Backpressure: out_rdy=0 for 10 cycles with in_vld=1 and changing inputs → out/out_vld stable, in_rdy=0, no second accept. Raise out_rdy → IDLE next cycle, then the new set is accepted.
- Reset mid-MAC: assert rst_n=0 at idx=2 → out_vld=0, out=0 immediately. After release in_rdy=1; the next transaction (bands 0x0100, gains 0x800) gives out=0x0500.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types, constants and clip helpers for the equalizer output stage.
// Used by band_scale_seq and band_scale_mac.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    localparam int unsigned NUM_BANDS = 5;
    localparam int unsigned ACC_W     = 19;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > 19'sd32767)
            return SAT_POS;
        else if (a < -19'sd32768)
            return SAT_NEG;
        else
            return a[15:0];
    endfunction

    function automatic logic clips16(input logic signed [ACC_W-1:0] a);
        return (a > 19'sd32767) || (a < -19'sd32768);
    endfunction

endpackage

// File: rtl/band_scale_mac.sv
// Combinational band term: signed sample times unsigned Q1.x gain, floored
// arithmetic shift back to sample scale, then clip to DATA_W.
module band_scale_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned GAIN_W = 12
) (
    input  logic signed [DATA_W-1:0] band_i,
    input  logic        [GAIN_W-1:0] gain_i,
    output logic signed [DATA_W-1:0] term_o,
    output logic                     clip_o
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;

    localparam logic signed [PROD_W-1:0] POS_LIM =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] NEG_LIM =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [GAIN_W:0]   gain_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    // Zero-extend so the gain multiplies as a non-negative signed operand.
    assign gain_s  = {1'b0, gain_i};
    assign prod    = band_i * gain_s;
    assign shifted = prod >>> (GAIN_W - 1);

    always_comb begin
        term_o = shifted[DATA_W-1:0];
        clip_o = 1'b0;
        if (shifted > POS_LIM) begin
            term_o = {1'b0, {(DATA_W-1){1'b1}}};
            clip_o = 1'b1;
        end else if (shifted < NEG_LIM) begin
            term_o = {1'b1, {(DATA_W-1){1'b0}}};
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/band_scale_seq.sv
// Time-multiplexed five-band scaler/summer on one shared multiplier.
// Optional SAT_FLAG_EN adds the sat_flag clip indicator port.
module band_scale_seq
    import eq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned GAIN_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] lp,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    input  logic [DATA_W-1:0] hp,
    input  logic [GAIN_W-1:0] g_lp,
    input  logic [GAIN_W-1:0] g_b1,
    input  logic [GAIN_W-1:0] g_b2,
    input  logic [GAIN_W-1:0] g_b3,
    input  logic [GAIN_W-1:0] g_hp,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out
`ifdef SAT_FLAG_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_BANDS - 1);

    state_e                   state_q;
    logic [2:0]               idx_q;
    logic signed [DATA_W-1:0] band_q [NUM_BANDS];
    logic        [GAIN_W-1:0] gain_q [NUM_BANDS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic        [DATA_W-1:0] out_q;
    logic                     out_vld_q;

    logic signed [DATA_W-1:0] cur_band;
    logic        [GAIN_W-1:0] cur_gain;
    logic signed [DATA_W-1:0] term;
    logic                     term_clip;

    always_comb begin
        cur_band = '0;
        cur_gain = '0;
        case (idx_q)
            3'd0: begin cur_band = band_q[0]; cur_gain = gain_q[0]; end
            3'd1: begin cur_band = band_q[1]; cur_gain = gain_q[1]; end
            3'd2: begin cur_band = band_q[2]; cur_gain = gain_q[2]; end
            3'd3: begin cur_band = band_q[3]; cur_gain = gain_q[3]; end
            3'd4: begin cur_band = band_q[4]; cur_gain = gain_q[4]; end
            default: ;
        endcase
    end

    band_scale_mac #(
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W)
    ) u_mac (
        .band_i(cur_band),
        .gain_i(cur_gain),
        .term_o(term),
        .clip_o(term_clip)
    );

    assign acc_d = acc_q + {{(ACC_W-DATA_W){term[DATA_W-1]}}, term};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                band_q[i] <= '0;
                gain_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        band_q[0] <= lp;
                        band_q[1] <= b1;
                        band_q[2] <= b2;
                        band_q[3] <= b3;
                        band_q[4] <= hp;
                        gain_q[0] <= g_lp;
                        gain_q[1] <= g_b1;
                        gain_q[2] <= g_b2;
                        gain_q[3] <= g_b3;
                        gain_q[4] <= g_hp;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    // The last term goes straight into the output clip, not acc_q.
                    if (idx_q == LAST_IDX) begin
                        out_q     <= sat16(acc_d);
                        out_vld_q <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= OUT;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 3'd1;
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rdy  = (state_q == IDLE);
    assign out     = out_q;
    assign out_vld = out_vld_q;

`ifdef SAT_FLAG_EN
    logic sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (state_q == IDLE && in_vld) begin
            sat_q <= 1'b0;
        end else if (state_q == MAC) begin
            sat_q <= sat_q | term_clip | ((idx_q == LAST_IDX) && clips16(acc_d));
        end
    end

    assign sat_flag = sat_q;
`endif

endmodule
